// File: rtl/vga_out_stage.sv
// vga_out_stage: retimes the Gigatron OUT byte onto the pixel grid, blanks
// colour outside the programmable active window, tracks line/frame position
// and reports horizontal lock plus a frame-start strobe.
module vga_out_stage #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned H_START    = 144,
    parameter int unsigned H_WIDTH    = 640,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       CLKx4,
    input  logic       RESET,
    input  logic [7:0] PIXIN,
    output logic       nHSYNC,
    output logic       nVSYNC,
    output logic [5:0] RGB,
    output logic       BLANK,
    output logic       FRAME_START,
    output logic [8:0] LINE,
    output logic [9:0] LINE_LEN,
    output logic       LOCKED
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned RGB_W  = 6;
    localparam int unsigned HCNT_W = 10;
    localparam int unsigned VCNT_W = 9;
    localparam int unsigned GOOD_W = 3;

    localparam logic [HCNT_W-1:0] HCNT_MAX   = {HCNT_W{1'b1}};
    localparam logic [HCNT_W-1:0] HACT_FIRST = HCNT_W'(H_START);
    localparam logic [HCNT_W:0]   HACT_END   = (HCNT_W+1)'(H_START + H_WIDTH);
    localparam logic [HCNT_W:0]   LINE_GOOD  = (HCNT_W+1)'(H_TOTAL);
    localparam logic [VCNT_W-1:0] VBACK_LAST = VCNT_W'(V_BACK - 1);
    localparam logic [VCNT_W-1:0] VACT_LAST  = VCNT_W'(V_LINES - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } vstate_e;

    logic [PIX_W-1:0]  p1_q, p1_d;
    logic [1:0]        sync_prev_q, sync_prev_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    vstate_e           state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [HCNT_W-1:0] line_len_q, line_len_d;
    logic              nhsync_q, nhsync_d;
    logic              nvsync_q, nvsync_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              blank_q, blank_d;
    logic              frame_start_q, frame_start_d;
    logic [VCNT_W-1:0] line_q, line_d;
    logic              locked_q, locked_d;

    logic hfall;
    logic vrise;
    logic hact;
    logic pix_on;

    // Edge detection and horizontal window decode on the stage-1 sample
    always_comb begin
        hfall  = !p1_q[6] && sync_prev_q[0];
        vrise  = p1_q[7] && !sync_prev_q[1];
        hact   = (hcnt_q >= HACT_FIRST) && ({1'b0, hcnt_q} < HACT_END);
        pix_on = (state_q == ST_ACTIVE) && hact;
    end

    // Next-state: input stage, horizontal counter, lock, vertical FSM, outputs
    always_comb begin
        p1_d          = PIXIN;
        sync_prev_d   = p1_q[7:6];
        hcnt_d        = hcnt_q;
        line_len_d    = line_len_q;
        good_d        = good_q;
        state_d       = state_q;
        vcnt_d        = vcnt_q;

        // Horizontal position; saturation marks a lost hsync
        if (hfall) begin
            hcnt_d     = '0;
            line_len_d = (hcnt_q == HCNT_MAX) ? HCNT_MAX : hcnt_q + HCNT_W'(1);
        end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
        end

        // Count consecutive lines of the expected length
        if (hfall) begin
            if (({1'b0, hcnt_q} + (HCNT_W+1)'(1)) == LINE_GOOD) begin
                good_d = (good_q == GOOD_LOCK) ? good_q : good_q + GOOD_W'(1);
            end else begin
                good_d = '0;
            end
        end else if (hcnt_q == HCNT_MAX) begin
            good_d = '0;
        end

        // Vertical sequencing; vsync low overrides everything
        if (!p1_q[7]) begin
            state_d = ST_SYNC;
        end else begin
            unique case (state_q)
                ST_SYNC: begin
                    if (vrise) begin
                        state_d = ST_BACK;
                        vcnt_d  = '0;
                    end
                end
                ST_BACK: begin
                    if (hfall) begin
                        if (vcnt_q == VBACK_LAST) begin
                            state_d = ST_ACTIVE;
                            vcnt_d  = '0;
                        end else begin
                            vcnt_d = vcnt_q + VCNT_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (hfall) begin
                        if (vcnt_q == VACT_LAST) begin
                            state_d = ST_FRONT;
                        end else begin
                            vcnt_d = vcnt_q + VCNT_W'(1);
                        end
                    end
                end
                ST_FRONT: begin
                    state_d = ST_FRONT;
                end
                default: begin
                    state_d = ST_FRONT;
                end
            endcase
        end

        nhsync_d      = p1_q[6];
        nvsync_d      = p1_q[7];
        rgb_d         = pix_on ? p1_q[5:0] : '0;
        blank_d       = !pix_on;
        frame_start_d = (state_q == ST_ACTIVE) && (vcnt_q == '0) && (hcnt_q == HACT_FIRST);
        line_d        = (state_q == ST_ACTIVE) ? vcnt_q : line_q;
        locked_d      = (good_d == GOOD_LOCK);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            p1_q          <= 8'hC0;
            sync_prev_q   <= 2'b11;
            hcnt_q        <= HCNT_MAX;
            line_len_q    <= '0;
            good_q        <= '0;
            state_q       <= ST_FRONT;
            vcnt_q        <= '0;
            nhsync_q      <= 1'b1;
            nvsync_q      <= 1'b1;
            rgb_q         <= '0;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            line_q        <= '0;
            locked_q      <= 1'b0;
        end else begin
            p1_q          <= p1_d;
            sync_prev_q   <= sync_prev_d;
            hcnt_q        <= hcnt_d;
            line_len_q    <= line_len_d;
            good_q        <= good_d;
            state_q       <= state_d;
            vcnt_q        <= vcnt_d;
            nhsync_q      <= nhsync_d;
            nvsync_q      <= nvsync_d;
            rgb_q         <= rgb_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            line_q        <= line_d;
            locked_q      <= locked_d;
        end
    end

    assign nHSYNC      = nhsync_q;
    assign nVSYNC      = nvsync_q;
    assign RGB         = rgb_q;
    assign BLANK       = blank_q;
    assign FRAME_START = frame_start_q;
    assign LINE        = line_q;
    assign LINE_LEN    = line_len_q;
    assign LOCKED      = locked_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// tb_vga_out_stage: directed frame streams on a scaled-down raster
// (80 clocks/line, 20 lines/frame) with hand-computed expectations.
module tb_vga_out_stage;

    localparam int unsigned TB_H_TOTAL = 80;
    localparam int unsigned TB_H_START = 14;
    localparam int unsigned TB_H_WIDTH = 64;
    localparam int unsigned TB_V_BACK  = 3;
    localparam int unsigned TB_V_LINES = 12;
    localparam int unsigned TB_LOCK    = 4;

    // Raster as driven: hsync low cols 0..9, vsync low lines 0..1,
    // active lines 5..16, active columns 15..78 (HCNT 14..77).
    localparam int HS_LOW     = 10;
    localparam int ACT_L0     = 5;
    localparam int ACT_L1     = 16;
    localparam int ACT_C0     = 15;
    localparam int ACT_C1     = 78;
    localparam int FRAME_LNS  = 20;

    logic       clk;
    logic       rst;
    logic [7:0] pixin;
    logic       n_hsync;
    logic       n_vsync;
    logic [5:0] rgb;
    logic       blank;
    logic       frame_start;
    logic [8:0] line;
    logic [9:0] line_len;
    logic       locked;

    int n_checks;
    int n_errors;
    int phase;
    int h_ph [2];
    int h_ln [2];
    int h_cl [2];

    vga_out_stage #(
        .H_TOTAL   (TB_H_TOTAL),
        .H_START   (TB_H_START),
        .H_WIDTH   (TB_H_WIDTH),
        .V_BACK    (TB_V_BACK),
        .V_LINES   (TB_V_LINES),
        .LOCK_COUNT(TB_LOCK)
    ) dut (
        .CLKx4      (clk),
        .RESET      (rst),
        .PIXIN      (pixin),
        .nHSYNC     (n_hsync),
        .nVSYNC     (n_vsync),
        .RGB        (rgb),
        .BLANK      (blank),
        .FRAME_START(frame_start),
        .LINE       (line),
        .LINE_LEN   (line_len),
        .LOCKED     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Directed checks keyed by (phase, line, column) of the pixel now on the outputs
    task automatic check_point(input int ph, input int ln, input int cl);
        if (ph == 1) begin
            if (ln == 0 && cl == 5) begin
                check("len_after_loss", 32'(line_len), 1023);
                check("unlocked_l0", 32'(locked), 0);
            end
            if (ln == 0 && cl == 40)  check("vsync_low", 32'(n_vsync), 0);
            if (ln == 1 && cl == 5)   check("len_l1", 32'(line_len), 80);
            if (ln == 2 && cl == 40)  check("vsync_high", 32'(n_vsync), 1);
            if (ln == 3 && cl == 70)  check("unlocked_l3", 32'(locked), 0);
            if (ln == 4 && cl == 5) begin
                check("locked_l4", 32'(locked), 1);
                check("len_l4", 32'(line_len), 80);
            end
            if (ln == 4 && cl == 40) begin
                check("bporch_blank", 32'(blank), 1);
                check("bporch_rgb", 32'(rgb), 0);
            end
            if (ln == 5 && cl == 14) begin
                check("pre_first_blank", 32'(blank), 1);
                check("pre_first_rgb", 32'(rgb), 0);
                check("pre_first_fs", 32'(frame_start), 0);
            end
            if (ln == 5 && cl == 15) begin
                check("first_rgb", 32'(rgb), 15);
                check("first_blank", 32'(blank), 0);
                check("first_fs", 32'(frame_start), 1);
                check("first_line", 32'(line), 0);
            end
            if (ln == 5 && cl == 16) begin
                check("second_rgb", 32'(rgb), 16);
                check("second_fs", 32'(frame_start), 0);
            end
            if (ln == 6 && cl == 5) begin
                check("hsync_low", 32'(n_hsync), 0);
                check("hsync_rgb", 32'(rgb), 0);
            end
            if (ln == 6 && cl == 12)  check("hsync_high", 32'(n_hsync), 1);
            if (ln == 6 && cl == 78) begin
                check("last_px_rgb", 32'(rgb), 14);
                check("last_px_blank", 32'(blank), 0);
            end
            if (ln == 6 && cl == 79) begin
                check("after_last_rgb", 32'(rgb), 0);
                check("after_last_blank", 32'(blank), 1);
            end
            if (ln == 10 && cl == 40) begin
                check("mid_line", 32'(line), 5);
                check("mid_rgb", 32'(rgb), 40);
            end
            if (ln == 16 && cl == 40) begin
                check("last_line", 32'(line), 11);
                check("last_line_rgb", 32'(rgb), 40);
                check("last_line_blank", 32'(blank), 0);
            end
            if (ln == 17 && cl == 40) begin
                check("fporch_rgb", 32'(rgb), 0);
                check("fporch_blank", 32'(blank), 1);
            end
            if (ln == 18 && cl == 40) check("line_hold", 32'(line), 11);
        end
        if (ph == 2) begin
            if (ln == 7 && cl == 40)  check("locked_pre_short", 32'(locked), 1);
            if (ln == 9 && cl == 5) begin
                check("unlock_short", 32'(locked), 0);
                check("len_short", 32'(line_len), 79);
            end
            if (ln == 12 && cl == 40) check("relock_3good", 32'(locked), 0);
            if (ln == 13 && cl == 5) begin
                check("relock_4good", 32'(locked), 1);
                check("len_relock", 32'(line_len), 80);
            end
        end
        if (ph == 3) begin
            if (ln == 8 && cl == 39) begin
                check("pre_abort_rgb", 32'(rgb), 39);
                check("pre_abort_blank", 32'(blank), 0);
                check("pre_abort_line", 32'(line), 3);
            end
            if (ln == 8 && cl == 41) begin
                check("abort_blank", 32'(blank), 1);
                check("abort_rgb", 32'(rgb), 0);
                check("abort_vsync", 32'(n_vsync), 0);
            end
        end
        if (ph == 4) begin
            if (ln == 1 && cl == 40) begin
                check("abort_line_hold", 32'(line), 3);
                check("abort_sync_blank", 32'(blank), 1);
            end
            if (ln == 4 && cl == 40)  check("resume_bporch_line", 32'(line), 3);
            if (ln == 5 && cl == 14)  check("resume_pre_fs", 32'(frame_start), 0);
            if (ln == 5 && cl == 15) begin
                check("resume_fs", 32'(frame_start), 1);
                check("resume_rgb", 32'(rgb), 15);
                check("resume_line", 32'(line), 0);
            end
            if (ln == 6 && cl == 40)  check("resume_line1", 32'(line), 1);
        end
    endtask

    // One pixel: check the outputs of the pixel driven two clocks ago, then drive
    task automatic step(input logic [7:0] v, input int ln, input int cl);
        @(negedge clk);
        check_point(h_ph[1], h_ln[1], h_cl[1]);
        h_ph[1] = h_ph[0];
        h_ln[1] = h_ln[0];
        h_cl[1] = h_cl[0];
        h_ph[0] = phase;
        h_ln[0] = ln;
        h_cl[0] = cl;
        pixin   = v;
    endtask

    // One raster line; vsync is forced low from column vs_col onward
    task automatic drive_line(input int ln, input int len, input int vs_col);
        logic       hs;
        logic       vs;
        logic [5:0] col;
        for (int c = 0; c < len; c++) begin
            hs  = (c >= HS_LOW);
            vs  = !((ln == 0) || (ln == 1) || (c >= vs_col));
            col = (ln >= ACT_L0 && ln <= ACT_L1 && c >= ACT_C0 && c <= ACT_C1) ? 6'(c) : 6'h3F;
            step({vs, hs, col}, ln, c);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        phase    = 0;
        h_ph     = '{0, 0};
        h_ln     = '{-1, -1};
        h_cl     = '{-1, -1};
        rst      = 1'b1;
        pixin    = 8'h00;

        // Reset values while both syncs are driven low
        repeat (3) step(8'h00, -1, -1);
        check("rst_nhsync", 32'(n_hsync), 1);
        check("rst_nvsync", 32'(n_vsync), 1);
        check("rst_rgb", 32'(rgb), 0);
        check("rst_blank", 32'(blank), 1);
        check("rst_fs", 32'(frame_start), 0);
        check("rst_line", 32'(line), 0);
        check("rst_line_len", 32'(line_len), 0);
        check("rst_locked", 32'(locked), 0);

        // Run part of a stream, reset mid-line, then idle high for 2000 clocks
        rst = 1'b0;
        drive_line(5, 80, 80);
        for (int c = 0; c < 30; c++) step(8'hC0 | 8'(c), -1, -1);
        rst = 1'b1;
        repeat (2) step(8'h55, -1, -1);
        rst = 1'b0;
        repeat (2000) step(8'hFF, -1, -1);
        check("idle_rgb", 32'(rgb), 0);
        check("idle_blank", 32'(blank), 1);
        check("idle_nhsync", 32'(n_hsync), 1);
        check("idle_nvsync", 32'(n_vsync), 1);
        check("idle_locked", 32'(locked), 0);
        check("idle_line_len", 32'(line_len), 0);
        check("idle_fs", 32'(frame_start), 0);

        // Frame 1: lock acquisition, window edges, line tracking
        phase = 1;
        for (int l = 0; l < FRAME_LNS; l++) drive_line(l, 80, 80);

        // Frame 2: one short line inside the active region
        phase = 2;
        for (int l = 0; l < FRAME_LNS; l++) drive_line(l, (l == 8) ? 79 : 80, 80);

        // Frame 3: vsync arrives mid-way through active line 3
        phase = 3;
        for (int l = 0; l < 8; l++) drive_line(l, 80, 80);
        drive_line(8, 80, 40);

        // Recovery: full vsync, back porch, then a new frame
        phase = 4;
        drive_line(0, 80, 80);
        drive_line(1, 80, 80);
        for (int l = 2; l < FRAME_LNS; l++) drive_line(l, 80, 80);
        phase = 0;
        repeat (3) step(8'hFF, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_out_stage.md
Name: vga_out_stage

Overview:
- Output stage directly downstream of the extension's video multiplexer.
- Consumes the 8-bit Gigatron OUT byte (bits 7:6 = vsync/hsync, active-low; bits 5:0 = BBGGRR) as driven after video snooping.
- Re-times sync and colour onto the CLKx4 pixel grid, forces colour to zero outside a programmable active window, and tracks line and frame position.
- Provides lock status and a frame-start strobe for later extension logic (e.g. a frame-synchronous bank switch).

Parameters:
- H_TOTAL, 800, expected CLKx4 cycles per line (hsync fall to hsync fall).
- H_START, 144, first active pixel, counted in CLKx4 cycles from hsync fall.
- H_WIDTH, 640, active pixels per line.
- V_BACK, 33, lines from vsync rise to first active line.
- V_LINES, 480, active lines per frame.
- LOCK_COUNT, 4, consecutive lines of length H_TOTAL required to assert LOCKED.

Ports:
- CLKx4 input 1: pixel clock (25 MHz); all logic on its rising edge.
- RESET input 1: synchronous, active-high reset.
- PIXIN input 8: OUT byte from the video multiplexer; changes only on CLKx4 falling edges.
- nHSYNC output 1: registered hsync, active-low.
- nVSYNC output 1: registered vsync, active-low.
- RGB output 6: registered colour, BBGGRR; zero when blanked.
- BLANK output 1: high outside the active window.
- FRAME_START output 1: one-cycle pulse on the first pixel of active line 0.
- LINE output 9: active line index 0..V_LINES-1; holds last value during blanking.
- LINE_LEN output 10: measured length of the last complete line.
- LOCKED output 1: line timing stable.

Behaviour:
- Pipeline:
  - Stage 1 registers PIXIN into P1.
  - Stage 2 registers outputs.
  - nHSYNC, nVSYNC and RGB all appear exactly 2 CLKx4 cycles after PIXIN, so sync and colour stay mutually aligned.
- Edge detect:
  - hfall = P1[6]==0 && previous P1[6]==1.
  - vrise = P1[7]==1 && previous P1[7]==0.
- HCNT (10 bits):
  - On hfall, HCNT<=0 and LINE_LEN<=HCNT+1. If HCNT==1023, LINE_LEN<=1023.
  - Otherwise HCNT increments and saturates at 1023.
- Horizontal active: hact = (H_START <= HCNT < H_START+H_WIDTH), evaluated on the same cycle as P1.
- Vertical FSM, states V_SYNC, V_BACK, V_ACTIVE, V_FRONT; VCNT is 9 bits.
  - Any state, P1[7]==0: go to V_SYNC.
  - V_SYNC, on vrise: go to V_BACK, VCNT<=0.
  - V_BACK: VCNT increments on each hfall. When VCNT reaches V_BACK-1 at an hfall, go to V_ACTIVE with VCNT<=0.
  - V_ACTIVE: VCNT increments on each hfall. On the hfall where VCNT==V_LINES-1, go to V_FRONT.
  - V_FRONT: wait for vsync.
- Simultaneous hfall and vsync low: the V_SYNC transition wins.
- LINE <= VCNT while in V_ACTIVE; otherwise LINE holds its value.
- BLANK = !(state==V_ACTIVE && hact). Registered in stage 2, aligned with RGB.
- RGB:
  - RGB <= P1[5:0] when not blanked, else 6'b0.
  - nHSYNC <= P1[6] and nVSYNC <= P1[7] regardless of blanking.
- FRAME_START is high for one cycle, aligned with the first stage-2 pixel where state==V_ACTIVE, VCNT==0 and HCNT==H_START.
- Lock:
  - On each hfall, if HCNT+1==H_TOTAL, a 3-bit good-line counter increments, saturating at LOCK_COUNT. Otherwise it clears to 0.
  - LOCKED is high while the counter equals LOCK_COUNT.
  - HCNT saturating at 1023 (hsync lost) clears the counter immediately.
- Reset:
  - nHSYNC=1, nVSYNC=1, RGB=0, BLANK=1, FRAME_START=0, LINE=0, LINE_LEN=0, LOCKED=0.
  - HCNT=1023 (saturated), state=V_FRONT, P1=8'hC0.
  - Reset in mid-frame discards all position state. Active output resumes only after a full vsync and back porch.

Test Plan:
- Reset mid-line, then PIXIN=8'hFF steady for 2000 cycles -> RGB=0, BLANK=1, nHSYNC=1, LOCKED=0, HCNT saturated.
- Standard 640x480 stream (hsync low 96 cycles every 800; vsync low 2 lines; colour 8'hC0|pixel index[5:0]) -> LOCKED rises at the 4th consecutive 800-cycle line, LINE_LEN=800.
- Same stream, check first active pixel -> appears on RGB 2 cycles after the PIXIN sample at HCNT=144 of line V_BACK after vsync. FRAME_START pulses on that exact cycle; LINE=0.
- Colour 6'h3F driven during the porches -> RGB=0 there. Pixel at HCNT=783 visible; HCNT=784 blanked. Line 479 visible; line 480 blanked; LINE holds 479.
- After lock, one line shortened to 799 cycles -> LOCKED drops at that hfall and reasserts after 4 good lines.
- Vsync asserted during V_ACTIVE line 200 -> immediate V_SYNC, BLANK=1. After vsync rise, 33 back-porch lines, then FRAME_START.
